// File: rtl/manchester_rx.sv
// Oversampled Manchester (IEEE 802.3 polarity) receiver: mid-bit phase tracking,
// preamble lock, start-of-frame delimiter search and LSB-first word deserialization.
module manchester_rx #(
    parameter int         OVERSAMPLE = 8,
    parameter int         DATA_W     = 8,
    parameter int         LOCK_BITS  = 8,
    parameter logic [7:0] SFD        = 8'hD5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              line_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              sync_lock,
    output logic              frame_end,
    output logic              code_err
);

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        PREAMBLE,
        SFD_SEARCH,
        DATA
    } state_t;

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int LCNT_W = $clog2(LOCK_BITS + 1);

    localparam logic [CNT_W-1:0]  CNT_Q1     = CNT_W'(OVERSAMPLE / 4);
    localparam logic [CNT_W-1:0]  CNT_Q3     = CNT_W'((3 * OVERSAMPLE) / 4);
    localparam logic [CNT_W-1:0]  CNT_RESYNC = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_W - 1);
    localparam logic [LCNT_W-1:0] LOCK_LAST  = LCNT_W'(LOCK_BITS - 1);

    state_t             state;
    logic               s1, s2, s3;
    logic [CNT_W-1:0]   cnt;
    logic               h1, h2;
    logic [LCNT_W-1:0]  lcnt;
    logic [7:0]         sreg;
    logic [DATA_W-1:0]  word;
    logic [IDX_W-1:0]   idx;

    logic               edge_det;
    logic               mid_edge;
    logic               wrap;
    logic               bit_ok;
    logic [7:0]         sreg_next;
    logic [DATA_W-1:0]  word_next;

    // line_in is asynchronous: s1/s2 synchronize it, s3 is the previous clean sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make s1->s2->s3 a true shift chain;
            // blocking ones would collapse it into a single flop.
            s1 <= line_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det  = s2 ^ s3;
    assign mid_edge  = edge_det && (cnt > CNT_Q1) && (cnt < CNT_Q3);
    assign wrap      = (cnt == CNT_LAST);
    assign bit_ok    = (h1 != h2);
    assign sreg_next = {h2, sreg[7:1]};
    assign word_next = {h2, word[DATA_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            h1         <= 1'b0;
            h2         <= 1'b0;
            lcnt       <= '0;
            sreg       <= '0;
            word       <= '0;
            idx        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sync_lock  <= 1'b0;
            frame_end  <= 1'b0;
            code_err   <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each pulse lasts exactly one clock.
            data_valid <= 1'b0;
            frame_end  <= 1'b0;
            code_err   <= 1'b0;

            if (!enable) begin
                state     <= IDLE;
                sync_lock <= 1'b0;
                cnt       <= '0;
            end else begin
                case (state)
                    IDLE: state <= HUNT;

                    // The first edge is taken as a mid-bit edge; the level before it is the
                    // first half of that bit, so it seeds h1 directly.
                    HUNT: begin
                        if (edge_det) begin
                            cnt   <= CNT_RESYNC;
                            h1    <= s3;
                            lcnt  <= '0;
                            state <= PREAMBLE;
                        end
                    end

                    default: begin
                        if (mid_edge)  cnt <= CNT_RESYNC;
                        else if (wrap) cnt <= '0;
                        else           cnt <= cnt + 1'b1;

                        if (cnt == CNT_Q1) h1 <= s2;
                        if (cnt == CNT_Q3) h2 <= s2;

                        if (wrap) begin
                            case (state)
                                PREAMBLE: begin
                                    if (bit_ok) begin
                                        sreg <= sreg_next;
                                        if (lcnt == LOCK_LAST) begin
                                            state     <= SFD_SEARCH;
                                            sync_lock <= 1'b1;
                                        end else begin
                                            lcnt <= lcnt + 1'b1;
                                        end
                                    end else begin
                                        state <= HUNT;
                                    end
                                end

                                SFD_SEARCH: begin
                                    if (bit_ok) begin
                                        sreg <= sreg_next;
                                        if (sreg_next == SFD) begin
                                            state <= DATA;
                                            idx   <= '0;
                                        end
                                    end else begin
                                        state     <= HUNT;
                                        sync_lock <= 1'b0;
                                        code_err  <= 1'b1;
                                    end
                                end

                                DATA: begin
                                    if (bit_ok) begin
                                        word <= word_next;
                                        if (idx == IDX_LAST) begin
                                            data_out   <= word_next;
                                            data_valid <= 1'b1;
                                            idx        <= '0;
                                        end else begin
                                            idx <= idx + 1'b1;
                                        end
                                    end else begin
                                        // A violation on a word boundary is the normal end of frame.
                                        state     <= HUNT;
                                        sync_lock <= 1'b0;
                                        if (idx == '0) frame_end <= 1'b1;
                                        else           code_err  <= 1'b1;
                                    end
                                end

                                default: state <= HUNT;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_manchester_rx.sv
// Self-checking bench for manchester_rx: a Manchester line driver with jitter and
// edge suppression, an event monitor, and a frame-level model of expected words/strobes.
module tb_manchester_rx;

    localparam int         OS    = 8;
    localparam int         DW    = 8;
    localparam int         LB    = 8;
    localparam logic [7:0] SFD_V = 8'hD5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          line_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          sync_lock;
    logic          frame_end;
    logic          code_err;

    manchester_rx #(
        .OVERSAMPLE(OS),
        .DATA_W    (DW),
        .LOCK_BITS (LB),
        .SFD       (SFD_V)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .line_in   (line_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .sync_lock (sync_lock),
        .frame_end (frame_end),
        .code_err  (code_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Monitor state
    logic [7:0] got_q[$];
    int         n_fe;
    int         n_ce;
    bit         lock_seen;
    bit         overlap;
    bit         long_strobe;
    logic       dv_d = 1'b0, fe_d = 1'b0, ce_d = 1'b0;

    // Stimulus description and model expectations
    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    int         kill_byte;
    int         kill_bit;
    bit         exp_fe;
    bit         exp_ce;
    int         jit_mode;
    int         jit_prev;
    int         jit_step;

    initial begin
        forever begin
            @(negedge clk);
            if (data_valid) got_q.push_back(data_out);
            if (frame_end) n_fe++;
            if (code_err) n_ce++;
            if (sync_lock) lock_seen = 1'b1;
            if (data_valid && frame_end) overlap = 1'b1;
            if ((data_valid && dv_d) || (frame_end && fe_d) || (code_err && ce_d)) long_strobe = 1'b1;
            dv_d = data_valid;
            fe_d = frame_end;
            ce_d = code_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Mid-bit offset per bit; consecutive offsets differ by at most one cycle.
    task automatic get_jitter(output int j);
        int lo, hi;
        case (jit_mode)
            1: begin
                case (jit_step % 4)
                    0:       j = 1;
                    2:       j = -1;
                    default: j = 0;
                endcase
            end
            2: begin
                lo = (jit_prev > 0) ? 0 : -1;
                hi = (jit_prev < 0) ? 0 : 1;
                j  = lo + int'($urandom_range(32'(hi - lo)));
            end
            default: j = 0;
        endcase
        jit_step++;
        jit_prev = j;
    endtask

    task automatic send_bit(input logic b, input bit kill);
        int j;
        get_jitter(j);
        line_in = ~b;
        repeat (OS / 2 + j) @(negedge clk);
        line_in = kill ? ~b : b;
        repeat (OS / 2 - j) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input int kbit);
        for (int i = 0; i < 8; i++) send_bit(v[i], i == kbit);
    endtask

    task automatic send_idle(input int nbits);
        line_in = 1'b0;
        repeat (nbits * OS) @(negedge clk);
    endtask

    task automatic send_frame();
        jit_prev = 0;
        jit_step = 0;
        send_byte(8'h55, -1);
        send_byte(SFD_V, -1);
        foreach (pay_q[k]) send_byte(pay_q[k], (k == kill_byte) ? kill_bit : -1);
        send_idle(4);
    endtask

    task automatic clear_mon();
        got_q.delete();
        n_fe        = 0;
        n_ce        = 0;
        lock_seen   = 1'b0;
        overlap     = 1'b0;
        long_strobe = 1'b0;
    endtask

    // Frame-level model: complete words before a damaged one are delivered; damage on
    // the first bit of a word reads as end of frame, anywhere else as a code error.
    task automatic model_frame();
        int nkeep;
        exp_q.delete();
        nkeep = (kill_byte < 0) ? pay_q.size() : kill_byte;
        for (int i = 0; i < nkeep; i++) exp_q.push_back(pay_q[i]);
        exp_fe = (kill_byte < 0) || (kill_bit == 0);
        exp_ce = (kill_byte >= 0) && (kill_bit != 0);
    endtask

    task automatic check_events(input string tag, input bit efe, input bit ece, input bit elock);
        int n;
        check({tag, " word count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, " frame_end count"}, 32'(n_fe), 32'(efe));
        check({tag, " code_err count"}, 32'(n_ce), 32'(ece));
        check({tag, " lock seen"}, 32'(lock_seen), 32'(elock));
        check({tag, " valid/end overlap"}, 32'(overlap), 32'd0);
        check({tag, " strobe width"}, 32'(long_strobe), 32'd0);
        check({tag, " sync_lock after"}, 32'(sync_lock), 32'd0);
    endtask

    task automatic run_frame(input string tag);
        clear_mon();
        model_frame();
        send_frame();
        check_events(tag, exp_fe, exp_ce, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " data_out"}, 32'(data_out), 32'd0);
        check({tag, " data_valid"}, 32'(data_valid), 32'd0);
        check({tag, " sync_lock"}, 32'(sync_lock), 32'd0);
        check({tag, " frame_end"}, 32'(frame_end), 32'd0);
        check({tag, " code_err"}, 32'(code_err), 32'd0);
    endtask

    task automatic random_payload(input int len);
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        line_in   = 1'b0;
        jit_mode  = 0;
        jit_prev  = 0;
        jit_step  = 0;
        kill_byte = -1;
        kill_bit  = -1;
        clear_mon();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        rst_n  = 1'b1;
        enable = 1'b1;
        send_idle(2);

        // Reference frame, clean timing
        pay_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_frame("basic");

        // Same frame with mid-bit edges shifted +1, 0, -1, 0 cycles
        jit_mode = 1;
        run_frame("jitter");
        jit_mode = 0;

        // Missing mid-bit edge on bit 3 of the only payload word
        pay_q     = '{8'hA5};
        kill_byte = 0;
        kill_bit  = 3;
        run_frame("bit3 violation");
        kill_byte = -1;
        kill_bit  = -1;
        random_payload(3);
        run_frame("after violation");

        // Six preamble bits then idle: never locks, no error
        clear_mon();
        exp_q.delete();
        jit_prev = 0;
        jit_step = 0;
        for (int i = 0; i < 6; i++) send_bit(logic'(i % 2 == 0), 1'b0);
        send_idle(4);
        check_events("short preamble", 1'b0, 1'b0, 1'b0);
        random_payload(2);
        run_frame("after short preamble");

        // One-cycle reset three bits into the second payload word
        pay_q = '{8'h12, 8'h34};
        clear_mon();
        exp_q = '{8'h12};
        fork
            send_frame();
            begin
                repeat (27 * OS) @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_all_zero("mid-frame reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        check_events("reset mid-frame", 1'b0, 1'b0, 1'b1);
        pay_q = '{8'h3C};
        run_frame("post-reset");

        // enable dropped four bits into the delimiter
        pay_q = '{8'h77};
        clear_mon();
        exp_q.delete();
        fork
            send_frame();
            begin
                repeat (12 * OS) @(negedge clk);
                check("lock before disable", 32'(sync_lock), 32'd1);
                enable = 1'b0;
                @(negedge clk);
                check("lock after disable", 32'(sync_lock), 32'd0);
            end
        join
        enable = 1'b1;
        send_idle(2);
        check_events("enable drop", 1'b0, 1'b0, 1'b1);
        random_payload(2);
        run_frame("after enable");

        // Randomized frames with random-walk jitter; every third one damages its last word
        jit_mode = 2;
        for (int f = 0; f < 9; f++) begin
            random_payload(1 + int'($urandom_range(3)));
            if (f % 3 == 2) begin
                kill_byte = pay_q.size() - 1;
                kill_bit  = int'($urandom_range(7));
            end else begin
                kill_byte = -1;
                kill_bit  = -1;
            end
            run_frame($sformatf("random%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/manchester_rx.md
# manchester_rx

Oversampled Manchester receiver: recovers bit timing from mid-bit transitions on an asynchronous serial line, locks on a preamble, finds a start-of-frame delimiter, and deserializes the payload into DATA_W-bit words. It is the decode/receive end of the Manchester link and consumes exactly what the Manchester transmitter emits. Its output feeds the frame buffer upstream.

## Interface
- OVERSAMPLE, 8: clk cycles per bit period; even, ≥8.
- DATA_W, 8: output word width.
- LOCK_BITS, 8: consecutive code-valid bits needed to declare lock.
- SFD, 8'hD5: start-of-frame delimiter, 8 bits, compared LSB-first.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  receiver enable; low forces IDLE.
- line_in  in  1  asynchronous Manchester line.
- data_out  out  DATA_W  last received word, LSB = first bit received.
- data_valid  out  1  one-cycle strobe, data_out is new.
- sync_lock  out  1  high from lock until frame end/error.
- frame_end  out  1  one-cycle strobe on clean end of frame.
- code_err  out  1  one-cycle strobe on Manchester violation after lock.

## Operation
- Encoding (IEEE 802.3): bit 1 = low→high mid-bit transition, bit 0 = high→low. Bits LSB-first.
- line_in passes a 2-flop synchronizer; edge = synchronized sample ≠ previous one.
- Phase counter cnt 0..OVERSAMPLE-1, wraps. Nominal mid-bit at cnt = OS/2.
- Edge with OS/4 < cnt < 3·OS/4 is mid-bit: cnt loads OS/2+1 next cycle (resync). Other edges (bit boundary) ignored.
- Half samples: h1 at cnt = OS/4, h2 at cnt = 3·OS/4. On wrap (cnt OS-1→0): h1≠h2 → bit = h2, valid; h1=h2 → violation.
- States:
  - IDLE: enable=0; all strobes low, sync_lock=0. enable=1 → HUNT.
  - HUNT: first edge loads cnt = OS/2+1, run counter, → PREAMBLE.
  - PREAMBLE: count valid bits; violation clears count and → HUNT (no code_err). Count = LOCK_BITS → SFD_SEARCH, sync_lock=1.
  - SFD_SEARCH: 8-bit shift register of received bits; match SFD → DATA, bit index 0. Violation → HUNT, code_err pulse, sync_lock=0.
  - DATA: shift bits into word register; after DATA_W bits, data_out updates, data_valid pulses, index wraps to 0. Violation at index 0 → frame_end pulse, → HUNT, no code_err. Violation at index ≠0 → code_err pulse, partial word discarded, → HUNT.
- Leaving DATA or SFD_SEARCH clears sync_lock in the same cycle as the strobe.
- enable dropping in any state → IDLE next cycle, no strobes, partial word discarded.

## Timing
- Reset values: data_out=0, data_valid=0, sync_lock=0, frame_end=0, code_err=0; state IDLE, cnt=0.
- Line-to-edge latency: 2 cycles (synchronizer) + 1 (edge detect).
- data_valid, frame_end, code_err: exactly one cycle, registered, asserted the cycle after the wrap that decides the final bit.
- sync_lock rises the cycle after the wrap completing the LOCK_BITS-th valid bit.
- Jitter tolerance: mid-bit edges within ±(OS/4-1) cycles of nominal keep lock.
- data_valid and frame_end never in the same cycle; frame_end follows last data_valid by ≥1 bit period.
- Reset asserted mid-frame: all outputs return to reset values immediately, no strobe emitted.

## Test plan
- OS=8: 8 bits of 0x55 preamble, SFD 0xD5, payload 0xEF,0xBE,0xAD,0xDE, then line idle low → data_valid ×4 with data_out 0xEF,0xBE,0xAD,0xDE, then one frame_end, sync_lock low, code_err never.
- Same frame with mid-bit edges alternately shifted ±1 cycle → identical words, no code_err.
- Payload 0xA5 with mid-bit edge suppressed on bit 3 → no data_valid for that word, one code_err, sync_lock falls, state HUNT; following full frame decodes correctly.
- Only 6 preamble bits then a violation → sync_lock never rises, no code_err; next full frame decodes.
- rst_n low for 1 cycle during second payload word → all outputs 0 at once, no strobe; later frame decodes 0x3C correctly.
- enable low during SFD search → sync_lock falls next cycle, no strobes; enable high then full frame → words received.
